// File: rtl/sha256_msg_feeder.sv
// sha256_msg_feeder
//   Packs a stream of big-endian 32-bit message words into 512-bit SHA-256
//   blocks, appends the 0x80 marker, zero padding and 64-bit bit length,
//   and sequences an external compression core block by block. The chaining
//   value is carried between blocks, and the final one is presented as the digest.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready word handshake; in_ready is high only while loading
//   in_data           message word, first byte in [31:23+1]
//   in_last/in_bytes  last-word marker and its left-aligned valid byte count
//   core_start        one-cycle pulse: core loads core_H / core_M
//   core_H, core_M    chaining value and message block (word 0 in MSBs)
//   core_H_out        updated chaining value, valid with core_done
//   core_done         one-cycle completion pulse from the core
//   digest            final hash, held until the next digest_valid
//   digest_valid      one-cycle pulse, digest valid in the same cycle
//   busy              low only when idle with no message in progress
module sha256_msg_feeder #(
  parameter int unsigned LEN_W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_data,
  input  logic           in_last,
  input  logic [2:0]     in_bytes,
  output logic           core_start,
  output logic [255:0]   core_H,
  output logic [511:0]   core_M,
  input  logic [255:0]   core_H_out,
  input  logic           core_done,
  output logic [255:0]   digest,
  output logic           digest_valid,
  output logic           busy
);

  localparam logic [255:0] H0 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {
    S_LOAD,
    S_PAD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [4:0]          r_widx;      // 0..16; 16 means block full, marker still owed
  logic [LEN_W-1:0]    r_bytecnt;
  logic [LEN_W-1:0]    w_bitlen;
  logic                r_pend80;
  logic                r_final;
  logic                r_padpend;   // another padding-only block follows
  logic                r_inmsg;
  logic [255:0]        r_chain;
  logic [255:0]        r_digest;
  logic [0:15][31:0]   r_buf;       // word 0 lands in the MSBs of core_M
  logic [2:0]          w_nb;
  logic [31:0]         w_lastword;

  assign w_nb     = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign w_bitlen = r_bytecnt << 3;

  always_comb begin
    w_lastword = 32'h8000_0000;
    case (w_nb)
      3'd1:    w_lastword = {in_data[31:24], 8'h80, 16'h0000};
      3'd2:    w_lastword = {in_data[31:16], 8'h80, 8'h00};
      3'd3:    w_lastword = {in_data[31:8], 8'h80};
      3'd4:    w_lastword = in_data;
      default: w_lastword = 32'h8000_0000;
    endcase
  end

  assign core_M = r_buf;
  assign core_H = r_chain;
  assign digest = r_digest;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    in_ready     = 1'b0;
    core_start   = 1'b0;
    digest_valid = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_last)                w_next = S_PAD;
          else if (r_widx == 5'd15)   w_next = S_ISSUE;
        end
      end
      S_PAD: begin
        if (r_widx == 5'd16 || r_widx == 5'd15 || (r_widx == 5'd14 && !r_pend80))
          w_next = S_ISSUE;
      end
      S_ISSUE: begin
        core_start = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          if (r_final)        w_next = S_DONE;
          else if (r_padpend) w_next = S_PAD;
          else                w_next = S_LOAD;
        end
      end
      S_DONE: begin
        digest_valid = 1'b1;
        w_next       = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
    busy = !(r_state == S_LOAD && r_widx == 5'd0 && !r_inmsg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_widx    <= '0;
      r_bytecnt <= '0;
      r_pend80  <= 1'b0;
      r_final   <= 1'b0;
      r_padpend <= 1'b0;
      r_inmsg   <= 1'b0;
      r_chain   <= H0;
      r_digest  <= '0;
      r_buf     <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_inmsg <= 1'b1;
            if (in_last) begin
              r_buf[r_widx[3:0]] <= w_lastword;
              r_bytecnt          <= r_bytecnt + LEN_W'(w_nb);
              r_pend80           <= (w_nb == 3'd4);
              r_widx             <= r_widx + 5'd1;
            end else begin
              r_buf[r_widx[3:0]] <= in_data;
              r_bytecnt          <= r_bytecnt + LEN_W'(3'd4);
              if (r_widx == 5'd15) begin
                r_widx    <= '0;
                r_padpend <= 1'b0;
              end else begin
                r_widx <= r_widx + 5'd1;
              end
            end
          end
        end
        S_PAD: begin
          if (r_widx == 5'd16) begin
            r_widx    <= '0;
            r_padpend <= 1'b1;
          end else if (r_widx == 5'd14 && !r_pend80) begin
            r_buf[14] <= w_bitlen[63:32];
            r_buf[15] <= w_bitlen[31:0];
            r_final   <= 1'b1;
            r_widx    <= '0;
          end else begin
            r_buf[r_widx[3:0]] <= r_pend80 ? 32'h8000_0000 : 32'h0000_0000;
            r_pend80           <= 1'b0;
            if (r_widx == 5'd15) begin
              r_widx    <= '0;
              r_padpend <= 1'b1;
            end else begin
              r_widx <= r_widx + 5'd1;
            end
          end
        end
        S_WAIT: begin
          if (core_done) begin
            r_chain   <= core_H_out;
            r_padpend <= 1'b0;
            // Digest is loaded together with the last chain update so it is
            // already valid during the DONE cycle that pulses digest_valid.
            if (r_final) r_digest <= core_H_out;
          end
        end
        S_DONE: begin
          r_chain   <= H0;
          r_bytecnt <= '0;
          r_pend80  <= 1'b0;
          r_final   <= 1'b0;
          r_padpend <= 1'b0;
          r_inmsg   <= 1'b0;
          r_widx    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
module tb_sha256_msg_feeder;

  localparam logic [255:0] H0 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam int LAT = 3;

  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         core_start;
  logic [255:0] core_H;
  logic [511:0] core_M;
  logic [255:0] core_H_out;
  logic         core_done;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;

  int checks = 0;
  int fails  = 0;

  sha256_msg_feeder #(.LEN_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
    .core_start(core_start), .core_H(core_H), .core_M(core_M),
    .core_H_out(core_H_out), .core_done(core_done),
    .digest(digest), .digest_valid(digest_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] h, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // Compression core model: fixed latency, real SHA-256 compression.
  logic [255:0] m_hout = '0;
  logic         m_done = 1'b0;
  int           m_cnt  = 0;
  logic [255:0] m_H    = '0;
  logic [511:0] m_M    = '0;
  logic         x_done = 1'b0;
  logic [255:0] x_hout = '0;
  int           n_starts = 0;
  int           n_dv = 0;
  logic [511:0] blk_q [$];

  assign core_done  = m_done | x_done;
  assign core_H_out = x_done ? x_hout : m_hout;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (m_cnt > 0) begin
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_hout <= sha_comp(m_H, m_M);
      end
      m_cnt <= m_cnt - 1;
    end
    if (core_start) begin
      m_H   <= core_H;
      m_M   <= core_M;
      m_cnt <= LAT;
      n_starts++;
      blk_q.push_back(core_M);
    end
    if (digest_valid) n_dv++;
  end

  bit mon_en = 1'b0;
  int ready_bad = 0;
  int hold_bad = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if ((core_start || m_cnt > 0 || m_done) && in_ready) ready_bad++;
      if ((m_cnt > 0 || m_done) && (core_M !== m_M || core_H !== m_H)) hold_bad++;
    end
  end

  logic [31:0] msg_w [0:31];

  task automatic send_msg(input int n, input logic [2:0] lastb);
    int budget;
    logic rdy;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = msg_w[i];
      in_last  = (i == n - 1);
      in_bytes = (i == n - 1) ? lastb : 3'd0;
      budget   = 0;
      forever begin
        rdy = in_ready;
        @(posedge clk); #1;
        if (rdy) break;
        budget++;
        if (budget > 200) begin
          checks++; fails++;
          $display("FAIL send_timeout word %0d: in_ready stayed 0, required 1 within 200 cycles", i);
          break;
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0; in_bytes = 3'd0; in_data = '0;
  endtask

  // Waits for digest_valid; cyc is the cycle number counted from the cycle
  // after the last word was accepted (1-based).
  task automatic wait_digest(output bit found, output int cyc, output logic [255:0] dg,
                             output logic dv_after, output logic [255:0] dg_after);
    cyc = 1; found = 1'b0; dg = '0;
    while (!digest_valid && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (digest_valid) begin
      found = 1'b1;
      dg = digest;
    end
    @(posedge clk); #1;
    dv_after = digest_valid;
    dg_after = digest;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (core_start !== 1'b0) begin fails++; $display("FAIL reset_core_start got %b want 0", core_start); end
    checks++; if (digest_valid !== 1'b0) begin fails++; $display("FAIL reset_digest_valid got %b want 0", digest_valid); end
    checks++; if (digest !== 256'd0) begin fails++; $display("FAIL reset_digest got %h want 0", digest); end
    checks++; if (core_H !== H0) begin fails++; $display("FAIL reset_core_H got %h want %h", core_H, H0); end
    checks++; if (core_M !== 512'd0) begin fails++; $display("FAIL reset_core_M got %h want 0", core_M); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_empty();
    int s0, cyc;
    bit found;
    logic [255:0] dg, dg2;
    logic dv2;
    logic [0:15][31:0] eb;
    s0 = n_starts;
    msg_w[0] = 32'hdeadbeef;
    send_msg(1, 3'd0);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL empty_busy got %b want 1", busy); end
    wait_digest(found, cyc, dg, dv2, dg2);
    checks++; if (!found) begin fails++; $display("FAIL empty_timeout digest_valid never seen, required within 400 cycles"); end
    checks++; if (dg !== D_EMPTY) begin fails++; $display("FAIL empty_digest got %h want %h", dg, D_EMPTY); end
    checks++; if (cyc != 14 + 1 + (LAT + 1) + 1) begin fails++; $display("FAIL empty_latency got %0d want %0d", cyc, 14 + 1 + (LAT + 1) + 1); end
    checks++; if (dv2 !== 1'b0) begin fails++; $display("FAIL empty_pulse digest_valid next cycle got %b want 0", dv2); end
    checks++; if (dg2 !== D_EMPTY) begin fails++; $display("FAIL empty_hold got %h want %h", dg2, D_EMPTY); end
    checks++; if (n_starts - s0 != 1) begin fails++; $display("FAIL empty_starts got %0d want 1", n_starts - s0); end
    eb = '0; eb[0] = 32'h8000_0000;
    checks++; if (blk_q[s0] !== eb) begin fails++; $display("FAIL empty_block got %h want %h", blk_q[s0], eb); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL empty_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_abc(input string nm);
    int s0, cyc;
    bit found;
    logic [255:0] dg, dg2;
    logic dv2;
    logic [0:15][31:0] eb;
    s0 = n_starts;
    msg_w[0] = 32'h616263ff;
    send_msg(1, 3'd3);
    wait_digest(found, cyc, dg, dv2, dg2);
    checks++; if (!found) begin fails++; $display("FAIL %s_timeout digest_valid never seen", nm); end
    checks++; if (dg !== D_ABC) begin fails++; $display("FAIL %s_digest got %h want %h", nm, dg, D_ABC); end
    checks++; if (cyc != 14 + 1 + (LAT + 1) + 1) begin fails++; $display("FAIL %s_latency got %0d want %0d", nm, cyc, 14 + 1 + (LAT + 1) + 1); end
    checks++; if (n_starts - s0 != 1) begin fails++; $display("FAIL %s_starts got %0d want 1", nm, n_starts - s0); end
    eb = '0; eb[0] = 32'h6162_6380; eb[15] = 32'h0000_0018;
    checks++; if (blk_q[s0] !== eb) begin fails++; $display("FAIL %s_block got %h want %h", nm, blk_q[s0], eb); end
  endtask

  task automatic test_two_block();
    int s0, cyc;
    bit found;
    logic [255:0] dg, dg2;
    logic dv2;
    logic [0:15][31:0] eb;
    logic [31:0] wds [0:13];
    wds = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
            32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
    for (int i = 0; i < 14; i++) msg_w[i] = wds[i];
    s0 = n_starts;
    mon_en = 1'b1;
    send_msg(14, 3'd4);
    wait_digest(found, cyc, dg, dv2, dg2);
    mon_en = 1'b0;
    checks++; if (dg !== D_TWO) begin fails++; $display("FAIL two_digest got %h want %h", dg, D_TWO); end
    checks++; if (n_starts - s0 != 2) begin fails++; $display("FAIL two_starts got %0d want 2", n_starts - s0); end
    eb = '0;
    for (int i = 0; i < 14; i++) eb[i] = wds[i];
    eb[14] = 32'h8000_0000;
    checks++; if (blk_q[s0] !== eb) begin fails++; $display("FAIL two_block1 got %h want %h", blk_q[s0], eb); end
    eb = '0; eb[15] = 32'h0000_01c0;
    checks++; if (blk_q[s0+1] !== eb) begin fails++; $display("FAIL two_block2 got %h want %h", blk_q[s0+1], eb); end
    checks++; if (hold_bad != 0) begin fails++; $display("FAIL two_hold core_M/core_H changed in %0d cycles, want 0", hold_bad); end
  endtask

  task automatic test_64byte();
    int s0, cyc;
    bit found;
    logic [255:0] dg, dg2, exp;
    logic dv2;
    logic [0:15][31:0] b1, b2;
    for (int i = 0; i < 16; i++) msg_w[i] = 32'h00010203 + 32'h04040404 * i;
    b1 = '0;
    for (int i = 0; i < 16; i++) b1[i] = msg_w[i];
    b2 = '0; b2[0] = 32'h8000_0000; b2[15] = 32'h0000_0200;
    exp = sha_comp(sha_comp(H0, b1), b2);
    s0 = n_starts;
    hold_bad = 0;
    mon_en = 1'b1;
    send_msg(16, 3'd4);
    wait_digest(found, cyc, dg, dv2, dg2);
    mon_en = 1'b0;
    checks++; if (n_starts - s0 != 2) begin fails++; $display("FAIL b64_starts got %0d want 2", n_starts - s0); end
    checks++; if (blk_q[s0] !== b1) begin fails++; $display("FAIL b64_block1 got %h want %h", blk_q[s0], b1); end
    checks++; if (blk_q[s0+1] !== b2) begin fails++; $display("FAIL b64_block2 got %h want %h", blk_q[s0+1], b2); end
    checks++; if (dg !== exp) begin fails++; $display("FAIL b64_digest got %h want %h", dg, exp); end
    checks++; if (hold_bad != 0) begin fails++; $display("FAIL b64_hold changed in %0d cycles, want 0", hold_bad); end
  endtask

  task automatic test_back_to_back();
    int s0, cyc;
    bit found;
    logic [255:0] dg, dg2, exp;
    logic dv2;
    logic [0:15][31:0] b1, b2;
    for (int i = 0; i < 20; i++) msg_w[i] = 32'ha500_0000 | 32'(i);
    b1 = '0;
    for (int i = 0; i < 16; i++) b1[i] = msg_w[i];
    b2 = '0;
    for (int i = 0; i < 4; i++) b2[i] = msg_w[16 + i];
    b2[4] = 32'h8000_0000; b2[15] = 32'h0000_0280;
    exp = sha_comp(sha_comp(H0, b1), b2);
    s0 = n_starts;
    ready_bad = 0; hold_bad = 0;
    mon_en = 1'b1;
    send_msg(20, 3'd4);
    wait_digest(found, cyc, dg, dv2, dg2);
    mon_en = 1'b0;
    checks++; if (ready_bad != 0) begin fails++; $display("FAIL b2b_ready in_ready high in %0d issue/wait cycles, want 0", ready_bad); end
    checks++; if (blk_q[s0] !== b1) begin fails++; $display("FAIL b2b_block1 got %h want %h", blk_q[s0], b1); end
    checks++; if (blk_q[s0+1] !== b2) begin fails++; $display("FAIL b2b_block2 got %h want %h", blk_q[s0+1], b2); end
    checks++; if (dg !== exp) begin fails++; $display("FAIL b2b_digest got %h want %h", dg, exp); end
    checks++; if (hold_bad != 0) begin fails++; $display("FAIL b2b_hold changed in %0d cycles, want 0", hold_bad); end
  endtask

  task automatic test_spurious_done();
    int dv0;
    dv0 = n_dv;
    x_hout = {8{32'h1234_5678}};
    x_done = 1'b1;
    @(posedge clk); #1;
    x_done = 1'b0;
    @(posedge clk); #1;
    checks++; if (core_H !== H0) begin fails++; $display("FAIL spur_chain got %h want %h", core_H, H0); end
    checks++; if (n_dv != dv0) begin fails++; $display("FAIL spur_dv got %0d pulses want 0", n_dv - dv0); end
    test_abc("spur_abc");
  endtask

  task automatic test_reset_abort();
    int dv0, budget;
    msg_w[0] = 32'h61626300;
    send_msg(1, 3'd3);
    budget = 0;
    while (!core_start && budget < 100) begin @(posedge clk); #1; budget++; end
    checks++; if (!core_start) begin fails++; $display("FAIL abort_start core_start never seen, required within 100 cycles"); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dv0 = n_dv;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (digest !== 256'd0) begin fails++; $display("FAIL abort_digest got %h want 0", digest); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (n_dv != dv0) begin fails++; $display("FAIL abort_dv got %0d pulses want 0", n_dv - dv0); end
    checks++; if (core_H !== H0) begin fails++; $display("FAIL abort_chain got %h want %h", core_H, H0); end
    test_abc("abort_abc");
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc("abc");
    test_two_block();
    test_64byte();
    test_back_to_back();
    test_spurious_done();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation still running at 2ms, required to finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sha256_msg_feeder.md
SHA256_MSG_FEEDER -- requirements
Module: sha256_msg_feeder

Interface
REQ-001 Parameter: LEN_W, 64, width of the message bit-length counter; only 64 is supported.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  input word offered.
REQ-005 in_ready  out  1  feeder accepts the word; a transfer occurs when in_valid && in_ready.
REQ-006 in_data  in  32  message word, big-endian; the first byte is in bits [31:24].
REQ-007 in_last  in  1  the word is the last word of the message.
REQ-008 in_bytes  in  3  valid bytes in the last word, left-aligned; 0..4 (5..7 treated as 4); ignored when in_last=0.
REQ-009 core_start  out  1  one-cycle pulse; the compression core loads core_H/core_M.
REQ-010 core_H  out  256  chaining value to the core, a in bits [255:224].
REQ-011 core_M  out  512  message block to the core, word 0 in bits [511:480].
REQ-012 core_H_out  in  256  updated chaining value from the core.
REQ-013 core_done  in  1  one-cycle pulse from the core; core_H_out is valid in that cycle.
REQ-014 digest  out  256  final hash; holds its value until the next digest_valid.
REQ-015 digest_valid  out  1  one-cycle pulse; digest is valid.
REQ-016 busy  out  1  high in every state except LOAD when word index = 0 and no message is in progress.

Function
REQ-017 States: LOAD, PAD, ISSUE, WAIT, DONE. in_ready=1 only in LOAD.
REQ-018 LOAD: each accepted word goes to buffer word widx, widx increments, and the byte count increments by 4 (by in_bytes on the last word).
REQ-019 Word 15 accepted with in_last=0 -> ISSUE with the pending flag cleared. widx wraps to 0 after issue.
REQ-020 Last word, in_bytes<4: byte 0x80 at byte position in_bytes, remaining bytes of the word are zero, widx++, -> PAD.
REQ-021 Last word, in_bytes=4: the word is stored unchanged, widx++, pend80 is set, -> PAD. An empty message is a last word with in_bytes=0, which yields word 0 = 0x80000000.
REQ-022 PAD, one word per cycle: if pend80, write 0x80000000 and clear pend80; else write zero.
REQ-023 PAD: when widx=14 and pend80=0, write bit length [63:32] at 14 and [31:0] at 15, set final, -> ISSUE.
REQ-024 PAD: if widx reaches 16 (from 15, or entered at 16) before length is written, -> ISSUE with final=0 and padding pending. After WAIT, -> PAD at widx=0 for the extra block.
REQ-025 Bit length = byte count x 8, modulo 2^64; it counts message bytes only, not padding.
REQ-026 ISSUE: core_start=1 for exactly one cycle, then -> WAIT.
REQ-027 core_M = buffer and core_H = chain; both are held constant from the core_start cycle through the core_done cycle inclusive.
REQ-028 chain = H0 (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19) for the first block of each message.
REQ-029 WAIT: on core_done, chain <= core_H_out. Next state: final -> DONE; padding pending -> PAD; otherwise -> LOAD.
REQ-030 DONE (1 cycle): digest <= chain, digest_valid=1, chain <= H0, counters, flags and widx cleared, -> LOAD.
REQ-031 core_done outside WAIT is ignored, and the chain is not updated.
REQ-032 in_valid or in_last outside LOAD has no effect; no word is lost because in_ready=0.
REQ-033 Latency: last word accepted to digest_valid = PAD cycles + 1 (ISSUE) + core latency + 1 (DONE).

Reset
REQ-034 rst=1 at any clock: state=LOAD, widx=0, byte count=0, pend80=0, final=0, chain=H0, in_ready=1 (registered from reset state), core_start=0, digest_valid=0, digest=0, busy=0, buffer=0.
REQ-035 rst during WAIT aborts the message: a later core_done is ignored and no digest_valid is produced.

Verification
REQ-036 Empty message (one word, in_last=1, in_bytes=0) -> one core_start, core_M word0=80000000, words 1..15 = 0 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-037 "abc" (61626300, in_bytes=3) -> core_M word0=61626380, word15=00000018 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-038 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> two core_starts; second block word15=000001c0 -> digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-039 64-byte message, last word in_bytes=4 at word 15 -> first block is the data unchanged; second block word0=80000000, word15=00000200; exactly 2 core_starts.
REQ-040 in_valid held high for the whole message -> in_ready=0 from ISSUE through WAIT, words accepted only in LOAD, word order preserved.
REQ-041 rst pulsed in WAIT, then "abc" sent -> no digest_valid for the aborted message, and the correct "abc" digest is produced.
